// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers for the Execute stage.
// A mult/div captures its operands on the start edge and holds busy for a fixed
// cycle count. HI/LO are written on the final edge from the captured copies.
// mthi/mtlo write HI/LO directly and never raise busy.
module mult_div_unit #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] operand1,
    input  logic [31:0] operand2,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int unsigned DATA_W     = 32;
    localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t              r_state;
    logic [CNT_W-1:0]    r_count;
    logic [2:0]          r_op;
    logic [DATA_W-1:0]   r_a;
    logic [DATA_W-1:0]   r_b;
    logic [DATA_W-1:0]   r_hi;
    logic [DATA_W-1:0]   r_lo;
    logic                r_busy;

    state_t              w_state_nxt;
    logic [CNT_W-1:0]    w_count_nxt;
    logic [DATA_W-1:0]   w_hi_nxt;
    logic [DATA_W-1:0]   w_lo_nxt;
    logic                w_capture;

    logic [2*DATA_W-1:0] w_prod_s;
    logic [2*DATA_W-1:0] w_prod_u;
    logic                w_a_neg;
    logic                w_b_neg;
    logic [DATA_W-1:0]   w_a_mag;
    logic [DATA_W-1:0]   w_b_mag;
    logic [DATA_W-1:0]   w_dvd;
    logic [DATA_W-1:0]   w_dvs;
    logic [DATA_W-1:0]   w_dvs_safe;
    logic [DATA_W-1:0]   w_q;
    logic [DATA_W-1:0]   w_r;
    logic [DATA_W-1:0]   w_q_s;
    logic [DATA_W-1:0]   w_r_s;
    logic                w_div0;

    // Products and quotients from the captured operands; signed divide works on magnitudes.
    always_comb begin
        w_prod_u   = {32'd0, r_a} * {32'd0, r_b};
        w_prod_s   = {{32{r_a[31]}}, r_a} * {{32{r_b[31]}}, r_b};
        w_a_neg    = (r_op == OP_DIV) && r_a[31];
        w_b_neg    = (r_op == OP_DIV) && r_b[31];
        w_a_mag    = w_a_neg ? (32'd0 - r_a) : r_a;
        w_b_mag    = w_b_neg ? (32'd0 - r_b) : r_b;
        w_dvd      = w_a_mag;
        w_dvs      = w_b_mag;
        w_div0     = (r_b == 32'd0);
        w_dvs_safe = w_div0 ? 32'd1 : w_dvs;
        w_q        = w_dvd / w_dvs_safe;
        w_r        = w_dvd % w_dvs_safe;
        w_q_s      = (w_a_neg ^ w_b_neg) ? (32'd0 - w_q) : w_q;
        w_r_s      = w_a_neg ? (32'd0 - w_r) : w_r;
    end

    // Next-state, countdown and HI/LO update logic.
    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_hi_nxt    = r_hi;
        w_lo_nxt    = r_lo;
        w_capture   = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    case (op)
                        OP_MULT, OP_MULTU: begin
                            w_capture   = 1'b1;
                            w_count_nxt = CNT_W'(MULT_CYCLES);
                            w_state_nxt = S_RUN;
                        end
                        OP_DIV, OP_DIVU: begin
                            w_capture   = 1'b1;
                            w_count_nxt = CNT_W'(DIV_CYCLES);
                            w_state_nxt = S_RUN;
                        end
                        OP_MTHI: w_hi_nxt = operand1;
                        OP_MTLO: w_lo_nxt = operand1;
                        default: ;
                    endcase
                end
            end
            S_RUN: begin
                if (r_count == CNT_W'(1)) begin
                    w_count_nxt = '0;
                    w_state_nxt = S_IDLE;
                    case (r_op)
                        OP_MULT: begin
                            w_hi_nxt = w_prod_s[63:32];
                            w_lo_nxt = w_prod_s[31:0];
                        end
                        OP_MULTU: begin
                            w_hi_nxt = w_prod_u[63:32];
                            w_lo_nxt = w_prod_u[31:0];
                        end
                        OP_DIV, OP_DIVU: begin
                            // A zero divisor leaves HI/LO untouched.
                            if (!w_div0) begin
                                w_hi_nxt = w_r_s;
                                w_lo_nxt = w_q_s;
                            end
                        end
                        default: ;
                    endcase
                end else begin
                    w_count_nxt = r_count - CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_count_nxt = '0;
            end
        endcase
    end

    // State, countdown, captured operands and HI/LO registers; reset wins over start.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_count <= '0;
            r_op    <= 3'd0;
            r_a     <= '0;
            r_b     <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
            r_hi    <= w_hi_nxt;
            r_lo    <= w_lo_nxt;
            r_busy  <= (w_state_nxt == S_RUN);
            if (w_capture) begin
                r_op <= op;
                r_a  <= operand1;
                r_b  <= operand2;
            end
        end
    end

    assign busy = r_busy;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule
